// File: rtl/axi_lite_regfile_pkg.sv
// Shared types, response codes and sizing helper for the AXI-Lite register bank.
package axi_lite_regfile_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_RESP} rd_state_e;

   // Index width for a register count; a single register still needs one bit.
   function automatic int idx_width(input int num_regs);
      return (num_regs <= 1) ? 1 : $clog2(num_regs);
   endfunction

endpackage

// File: rtl/axi_lite_regfile_decode.sv
// Address decoder: maps a bus address to a register index and an in-range flag.
module axi_lite_regfile_decode
   import axi_lite_regfile_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_STRB_WIDTH = 4,
   parameter int NUM_REGS       = 16,
   parameter int WINDOW_BITS    = 13,
   parameter int IDX_W          = idx_width(NUM_REGS)
) (
   input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
   output logic [IDX_W-1:0]          o_idx,
   output logic                      o_hit
);

   localparam int ADDR_LSB = $clog2(AXI_STRB_WIDTH);
   localparam int OFF_W    = WINDOW_BITS - ADDR_LSB;
   localparam logic [AXI_ADDR_WIDTH-1:0] ONE = AXI_ADDR_WIDTH'(1);
   localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MASK =
      ((ONE << WINDOW_BITS) - ONE) & ~((ONE << ADDR_LSB) - ONE);

   logic [OFF_W-1:0] w_offset;
   logic             w_unused;

   assign w_offset = i_addr[WINDOW_BITS-1:ADDR_LSB];
   assign o_hit    = (w_offset < OFF_W'(NUM_REGS));
   assign o_idx    = w_offset[IDX_W-1:0];

   // Byte-lane bits and bits above the window carry no meaning here.
   assign w_unused = ^(i_addr & ~OFF_MASK);

endmodule

// File: rtl/axi_lite_regfile_simple.sv
// AXI-Lite slave register bank with parallel hardware view and per-register hardware updates.
// Optional macro AXI_LITE_REGFILE_WR_PULSE_EN adds wr_pulse_o, one pulse per committed bus write.
module axi_lite_regfile_simple
   import axi_lite_regfile_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int NUM_REGS       = 16,
   parameter int WINDOW_BITS    = 13
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [AXI_ADDR_WIDTH-1:0]          in_aw_addr,
   input  logic [2:0]                         in_aw_prot,
   input  logic                               in_aw_valid,
   output logic                               in_aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]          in_w_data,
   input  logic [AXI_STRB_WIDTH-1:0]          in_w_strb,
   input  logic                               in_w_valid,
   output logic                               in_w_ready,
   output logic [1:0]                         in_b_resp,
   output logic                               in_b_valid,
   input  logic                               in_b_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]          in_ar_addr,
   input  logic [2:0]                         in_ar_prot,
   input  logic                               in_ar_valid,
   output logic                               in_ar_ready,
   output logic [AXI_DATA_WIDTH-1:0]          in_r_data,
   output logic [1:0]                         in_r_resp,
   output logic                               in_r_valid,
   input  logic                               in_r_ready,
   output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q_o,
   input  logic [NUM_REGS-1:0]                hw_we_i,
   input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] hw_wdata_i
`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
   ,
   output logic [NUM_REGS-1:0]                wr_pulse_o
`endif
);

   localparam int DW    = AXI_DATA_WIDTH;
   localparam int IDX_W = idx_width(NUM_REGS);

   wr_state_e r_wr_state, w_wr_state_nxt;
   rd_state_e r_rd_state, w_rd_state_nxt;

   logic                      r_aw_held, r_w_held, r_aw_hit;
   logic [IDX_W-1:0]          r_aw_idx;
   logic [DW-1:0]             r_w_data;
   logic [AXI_STRB_WIDTH-1:0] r_w_strb;
   logic [1:0]                r_b_resp, r_r_resp;
   logic [DW-1:0]             r_r_data;
   logic [DW-1:0]             r_regs [NUM_REGS];

   logic [IDX_W-1:0]          w_aw_idx, w_ar_idx, w_wr_idx;
   logic                      w_aw_hit, w_ar_hit, w_wr_hit;
   logic                      w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [DW-1:0]             w_wr_data;
   logic [AXI_STRB_WIDTH-1:0] w_wr_strb;
   logic [NUM_REGS-1:0]       w_bus_we;
   logic                      w_unused_prot;

   axi_lite_regfile_decode #(
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_STRB_WIDTH(AXI_STRB_WIDTH),
      .NUM_REGS(NUM_REGS), .WINDOW_BITS(WINDOW_BITS), .IDX_W(IDX_W)
   ) u_aw_decode (.i_addr(in_aw_addr), .o_idx(w_aw_idx), .o_hit(w_aw_hit));

   axi_lite_regfile_decode #(
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_STRB_WIDTH(AXI_STRB_WIDTH),
      .NUM_REGS(NUM_REGS), .WINDOW_BITS(WINDOW_BITS), .IDX_W(IDX_W)
   ) u_ar_decode (.i_addr(in_ar_addr), .o_idx(w_ar_idx), .o_hit(w_ar_hit));

   assign w_unused_prot = ^{in_aw_prot, in_ar_prot};

   assign w_aw_hs = in_aw_valid && in_aw_ready;
   assign w_w_hs  = in_w_valid  && in_w_ready;
   assign w_ar_hs = in_ar_valid && in_ar_ready;

   // A channel accepted this very cycle is used directly rather than from its holding register.
   assign w_wr_idx  = r_aw_held ? r_aw_idx : w_aw_idx;
   assign w_wr_hit  = r_aw_held ? r_aw_hit : w_aw_hit;
   assign w_wr_data = r_w_held  ? r_w_data : in_w_data;
   assign w_wr_strb = r_w_held  ? r_w_strb : in_w_strb;

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_wr_state_nxt = r_wr_state;
      in_aw_ready    = 1'b0;
      in_w_ready     = 1'b0;
      in_b_valid     = 1'b0;
      w_commit       = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            in_aw_ready = !r_aw_held;
            in_w_ready  = !r_w_held;
            w_commit    = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
            if (w_commit) w_wr_state_nxt = W_RESP;
         end
         W_RESP: begin
            in_b_valid = 1'b1;
            if (in_b_ready) w_wr_state_nxt = W_IDLE;
         end
      endcase
   end

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      in_ar_ready    = 1'b0;
      in_r_valid     = 1'b0;
      case (r_rd_state)
         R_IDLE: begin
            in_ar_ready = 1'b1;
            if (in_ar_valid) w_rd_state_nxt = R_RESP;
         end
         R_RESP: begin
            in_r_valid = 1'b1;
            if (in_r_ready) w_rd_state_nxt = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_rd_state <= w_rd_state_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_idx  <= '0;
         r_aw_hit  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_b_resp  <= RESP_OKAY;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= w_aw_idx;
            r_aw_hit  <= w_aw_hit;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_w_data <= in_w_data;
            r_w_strb <= in_w_strb;
         end
         if (w_commit) r_b_resp <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
         if (r_wr_state == W_RESP && in_b_ready) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++)
         w_bus_we[k] = w_commit && w_wr_hit && (w_wr_idx == IDX_W'(k));
   end

   // NOTE: the bank is reset word by word so software always starts from zero; this keeps it in flops.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
               if (w_bus_we[k] && w_wr_strb[b])
                  r_regs[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
               else if (hw_we_i[k])
                  r_regs[k][b*8 +: 8] <= hw_wdata_i[k*DW + b*8 +: 8];
            end
         end
      end
   end

   // NOTE: non-blocking updates mean a read sees the register value from before this edge's writes.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_r_data <= '0;
         r_r_resp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_r_data <= w_ar_hit ? r_regs[w_ar_idx] : '0;
         r_r_resp <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign in_b_resp = r_b_resp;
   assign in_r_data = r_r_data;
   assign in_r_resp = r_r_resp;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_q
      assign reg_q_o[k*DW +: DW] = r_regs[k];
   end

`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
   logic [NUM_REGS-1:0] r_wr_pulse;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_wr_pulse <= '0;
      else         r_wr_pulse <= w_bus_we;
   end

   assign wr_pulse_o = r_wr_pulse;
`endif

endmodule

// File: tb/tb_axi_lite_regfile_simple.sv
// Directed self-checking bench for axi_lite_regfile_simple against a word/byte-mask register model.
module tb_axi_lite_regfile_simple;

   localparam int NR = 16;
   localparam int DW = 32;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic              rst_ni;
   logic [31:0]       in_aw_addr, in_ar_addr, in_w_data;
   logic [2:0]        in_aw_prot, in_ar_prot;
   logic              in_aw_valid, in_aw_ready, in_w_valid, in_w_ready;
   logic [3:0]        in_w_strb;
   logic [1:0]        in_b_resp, in_r_resp;
   logic              in_b_valid, in_b_ready, in_ar_valid, in_ar_ready;
   logic [31:0]       in_r_data;
   logic              in_r_valid, in_r_ready;
   logic [NR*DW-1:0]  reg_q_o, hw_wdata_i;
   logic [NR-1:0]     hw_we_i;
`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
   logic [NR-1:0]     wr_pulse_o;
   logic [NR-1:0]     exp_pulse = '0;
`endif

   axi_lite_regfile_simple dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_aw_addr(in_aw_addr), .in_aw_prot(in_aw_prot), .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready),
      .in_w_data(in_w_data), .in_w_strb(in_w_strb), .in_w_valid(in_w_valid), .in_w_ready(in_w_ready),
      .in_b_resp(in_b_resp), .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
      .in_ar_addr(in_ar_addr), .in_ar_prot(in_ar_prot), .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready),
      .in_r_data(in_r_data), .in_r_resp(in_r_resp), .in_r_valid(in_r_valid), .in_r_ready(in_r_ready),
      .reg_q_o(reg_q_o), .hw_we_i(hw_we_i), .hw_wdata_i(hw_wdata_i)
`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
      , .wr_pulse_o(wr_pulse_o)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] m_regs [NR];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Word offset within the 8 KiB window, 4-byte words.
   function automatic logic model_hit(input logic [31:0] addr);
      return addr[12:2] < 11'd16;
   endfunction

   function automatic logic [NR*DW-1:0] model_vec();
      logic [NR*DW-1:0] v;
      for (int k = 0; k < NR; k++) v[k*DW +: DW] = m_regs[k];
      return v;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int hw_k, input logic [31:0] hw_data);
      if (hw_k >= 0) m_regs[hw_k] = hw_data;
      if (model_hit(addr)) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_regs[addr[5:2]][8*b +: 8] = data[8*b +: 8];
`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
         exp_pulse = NR'(1) << addr[5:2];
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
      exp_pulse = '0;
`endif
   endtask

   task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lag, input int b_hold,
                           input int hw_k, input logic [31:0] hw_data, output logic [1:0] resp_got);
      bit aw_done = 0, w_done = 0, committed = 0, aw_now, w_now;
      int cyc = 0;
      logic [1:0] exp_resp;
      exp_resp    = model_hit(addr) ? 2'b00 : 2'b10;
      in_aw_addr  = addr;
      in_aw_valid = 1'b1;
      in_w_data   = data;
      in_w_strb   = strb;
      while (!committed && cyc < 50) begin
         in_w_valid = !w_done && (cyc >= w_lag);
         if (aw_done) check({name, " aw_ready held low"}, in_aw_ready, 0);
         if (w_done)  check({name, " w_ready held low"}, in_w_ready, 0);
         aw_now    = in_aw_valid && in_aw_ready;
         w_now     = in_w_valid && in_w_ready;
         committed = (aw_done || aw_now) && (w_done || w_now);
         if (committed && hw_k >= 0) begin
            hw_we_i[hw_k]             = 1'b1;
            hw_wdata_i[hw_k*DW +: DW] = hw_data;
         end
         tick();
         aw_done = aw_done || aw_now;
         w_done  = w_done || w_now;
         if (aw_done) in_aw_valid = 1'b0;
         if (w_done)  in_w_valid  = 1'b0;
         hw_we_i = '0;
         cyc++;
      end
      in_aw_valid = 1'b0;
      in_w_valid  = 1'b0;
      if (!committed) check({name, " commit timeout"}, 0, 1);
      else model_write(addr, data, strb, hw_k, hw_data);
      resp_got = in_b_resp;
      check({name, " b_valid"}, in_b_valid, 1);
      check({name, " b_resp"}, in_b_resp, exp_resp);
      repeat (b_hold) begin
         tick();
         check({name, " b_valid stall"}, in_b_valid, 1);
         check({name, " b_resp stall"}, in_b_resp, exp_resp);
         check({name, " readies stall"}, {in_aw_ready, in_w_ready}, 2'b00);
      end
      in_b_ready = 1'b1;
      tick();
      in_b_ready = 1'b0;
      check({name, " b_valid drop"}, in_b_valid, 0);
      check({name, " readies back"}, {in_aw_ready, in_w_ready}, 2'b11);
   endtask

   task automatic do_read(input string name, input logic [31:0] addr, input int r_hold,
                          output logic [31:0] got);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      bit done = 0;
      int cyc = 0;
      exp_d = '0;
      exp_r = model_hit(addr) ? 2'b00 : 2'b10;
      in_ar_addr  = addr;
      in_ar_valid = 1'b1;
      while (!done && cyc < 50) begin
         done  = in_ar_ready;
         exp_d = model_hit(addr) ? m_regs[addr[5:2]] : 32'h0;
         tick();
         cyc++;
      end
      in_ar_valid = 1'b0;
      if (!done) check({name, " ar timeout"}, 0, 1);
      got = in_r_data;
      check({name, " r_valid"}, in_r_valid, 1);
      check({name, " r_data"}, in_r_data, exp_d);
      check({name, " r_resp"}, in_r_resp, exp_r);
      check({name, " ar_ready busy"}, in_ar_ready, 0);
      repeat (r_hold) begin
         tick();
         check({name, " r stall"}, {in_r_valid, in_r_resp, in_r_data}, {1'b1, exp_r, exp_d});
      end
      in_r_ready = 1'b1;
      tick();
      in_r_ready = 1'b0;
      check({name, " r_valid drop"}, in_r_valid, 0);
      check({name, " ar_ready back"}, in_ar_ready, 1);
   endtask

   // Register contents (and write pulses) must track the model on every cycle.
   initial begin
      @(posedge clk_i);
      forever begin
         @(negedge clk_i);
         check("reg_q", reg_q_o, model_vec());
`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
         check("wr_pulse", wr_pulse_o, exp_pulse);
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [1:0]  resp;
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      rst_ni = 1'b0;
      in_aw_addr = '0; in_aw_prot = 3'b010; in_aw_valid = 1'b0;
      in_w_data = '0; in_w_strb = '0; in_w_valid = 1'b0; in_b_ready = 1'b0;
      in_ar_addr = '0; in_ar_prot = 3'b101; in_ar_valid = 1'b0; in_r_ready = 1'b0;
      hw_we_i = '0; hw_wdata_i = '0;
      repeat (3) tick();
      rst_ni = 1'b1;
      check("reset readies", {in_aw_ready, in_w_ready, in_ar_ready}, 3'b111);
      check("reset valids", {in_b_valid, in_r_valid}, 2'b00);
      check("reset resp/data", {in_b_resp, in_r_resp, in_r_data}, 36'h0);

      do_write("wr_same_cycle", 32'h0004, 32'hDEADBEEF, 4'hF, 0, 0, -1, 0, resp);
      check("reg1 literal", reg_q_o[1*DW +: DW], 32'hDEADBEEF);
      do_read("rd_reg1", 32'h0004, 0, got);
      check("rd_reg1 literal", got, 32'hDEADBEEF);

      do_write("wr_w_late", 32'h0008, 32'h12345678, 4'hF, 5, 4, -1, 0, resp);

      do_write("wr_reg2_full", 32'h0008, 32'hAABBCCDD, 4'hF, 0, 0, -1, 0, resp);
      do_write("wr_reg2_strb", 32'h0008, 32'h11223344, 4'b0101, 0, 1, -1, 0, resp);
      check("reg2 strobe literal", reg_q_o[2*DW +: DW], 32'hAA22CC44);
      do_read("rd_reg2", 32'h0008, 2, got);

      do_read("rd_oob", 32'h0040, 1, got);
      check("rd_oob data literal", got, 32'h0);
      check("rd_oob resp literal", in_r_resp, 2'b10);
      do_write("wr_oob", 32'h1FFC, 32'hCAFEF00D, 4'hF, 0, 0, -1, 0, resp);
      check("wr_oob resp literal", resp, 2'b10);

      do_write("wr_hw_merge", 32'h000C, 32'h00000000, 4'b0011, 0, 0, 3, 32'hFFFFFFFF, resp);
      check("reg3 merge literal", reg_q_o[3*DW +: DW], 32'hFFFF0000);

      hw_we_i[5] = 1'b1;
      hw_wdata_i[5*DW +: DW] = 32'h5A5AA5A5;
      tick();
      hw_we_i = '0;
      m_regs[5] = 32'h5A5AA5A5;
      do_read("rd_hw_only", 32'h0014, 0, got);

      do_write("wr_last", 32'h003C, 32'h0F0F0F0F, 4'hF, 0, 0, -1, 0, resp);
      do_write("wr_upper_bits", 32'hABCD_E010, 32'h87654321, 4'hF, 2, 0, -1, 0, resp);
      do_read("rd_low_bits", 32'h0000_0013, 0, got);
      check("upper/low bits literal", got, 32'h87654321);
      do_write("wr_strb0", 32'h0004, 32'h00000000, 4'h0, 0, 0, -1, 0, resp);
      check("wr_strb0 resp literal", resp, 2'b00);

      // Park both channels in their response states, then reset.
      in_aw_addr = 32'h0014; in_aw_valid = 1'b1;
      in_w_data = 32'h13579BDF; in_w_strb = 4'hF; in_w_valid = 1'b1;
      in_ar_addr = 32'h0004; in_ar_valid = 1'b1;
      tick();
      model_write(32'h0014, 32'h13579BDF, 4'hF, -1, 0);
      in_aw_valid = 1'b0; in_w_valid = 1'b0; in_ar_valid = 1'b0;
      check("parked valids", {in_b_valid, in_r_valid}, 2'b11);
      tick();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      check("mid reset valids", {in_b_valid, in_r_valid}, 2'b00);
      check("mid reset readies", {in_aw_ready, in_w_ready, in_ar_ready}, 3'b111);
      check("mid reset data", {in_b_resp, in_r_resp, in_r_data}, 36'h0);
      check("mid reset regs", reg_q_o, '0);

      do_write("wr_after_reset", 32'h0018, 32'h24681357, 4'hF, 1, 0, -1, 0, resp);
      do_read("rd_after_reset", 32'h0018, 0, got);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_regfile_simple.md
Name: axi_lite_regfile_simple

Overview:
- AXI-Lite slave register bank that terminates one master port of the AXI-Lite crossbar. Attaches directly to one of its flattened `out_*` port slices.
- Holds NUM_REGS software-accessible 32-bit words at the bottom of its 8 KiB address window.
- Exposes all register contents to hardware in parallel and accepts per-register hardware updates.

Parameters:
- AXI_ADDR_WIDTH, 32, address width; must match the crossbar.
- AXI_DATA_WIDTH, 32, data width (32 or 64).
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width.
- NUM_REGS, 16, number of registers; range 1..256.
- WINDOW_BITS, 13, width of the decoded window (0x2000 bytes per crossbar rule).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- in_aw_addr  in  AXI_ADDR_WIDTH  write address
- in_aw_prot  in  3  ignored
- in_aw_valid / in_aw_ready  in/out  1  AW handshake
- in_w_data  in  AXI_DATA_WIDTH  write data
- in_w_strb  in  AXI_STRB_WIDTH  byte enables
- in_w_valid / in_w_ready  in/out  1  W handshake
- in_b_resp  out  2  write response
- in_b_valid / in_b_ready  out/in  1  B handshake
- in_ar_addr  in  AXI_ADDR_WIDTH  read address
- in_ar_prot  in  3  ignored
- in_ar_valid / in_ar_ready  in/out  1  AR handshake
- in_r_data  out  AXI_DATA_WIDTH  read data
- in_r_resp  out  2  read response
- in_r_valid / in_r_ready  out/in  1  R handshake
- reg_q_o  out  NUM_REGS*AXI_DATA_WIDTH  register contents; reg k occupies bits [k*DW +: DW]
- hw_we_i  in  NUM_REGS  hardware write enable per register
- hw_wdata_i  in  NUM_REGS*AXI_DATA_WIDTH  hardware write data, same packing as reg_q_o

Behaviour:
- Decode:
  - ADDR_LSB = log2(AXI_STRB_WIDTH); offset = addr[WINDOW_BITS-1:ADDR_LSB]; bits below ADDR_LSB are ignored.
  - offset < NUM_REGS: OKAY (2'b00).
  - offset >= NUM_REGS: SLVERR (2'b10); writes are dropped and read data is 0.
  - Address bits above the window are ignored; the crossbar has already routed the transaction.
- Reset (while rst_ni=0 at a clock edge):
  - All registers return to 0.
  - Outputs: aw_ready=1, w_ready=1, ar_ready=1, b_valid=0, r_valid=0, b_resp=0, r_resp=0, r_data=0.
  - A reset mid-transaction abandons the transaction; no response is issued.
- Write FSM, states W_IDLE / W_RESP:
  - In W_IDLE, AW and W are accepted independently. Each has a holding flag; aw_ready = !aw_held, w_ready = !w_held.
  - Same-cycle AW+W acceptance is allowed.
  - Once both are held (including via this cycle's handshakes), the strobed write is committed at the next edge and the FSM enters W_RESP with b_valid=1.
  - The minimum latency is 1 cycle from the last of the AW/W handshakes to b_valid.
  - In W_RESP: aw_ready=w_ready=0; b_valid and b_resp stay stable until b_ready. The FSM then returns to W_IDLE and clears both flags.
- Read FSM, states R_IDLE / R_RESP:
  - ar_ready=1 only in R_IDLE.
  - On an AR handshake, r_data/r_resp are registered from the register value before that edge's writes. The FSM enters R_RESP with r_valid=1, so latency is 1 cycle.
  - r_valid, r_data and r_resp are held stable until r_ready, then the FSM returns to R_IDLE. There is no back-to-back read without an idle cycle.
  - Read and write paths are fully independent.
- Byte strobes: byte b of the target register is updated only when w_strb[b]=1. strb=0 still returns OKAY.
- Hardware writes:
  - hw_we_i[k] loads hw_wdata_i word k at the edge.
  - When a bus write commits to the same register in the same cycle, the bus write wins for every strobed byte; hw data fills the unstrobed bytes.
- reg_q_o is driven directly from the flops, with no extra latency.

Optional Feature:
- Macro: AXI_LITE_REGFILE_WR_PULSE_EN.
- Defined:
  - Adds output port wr_pulse_o [NUM_REGS].
  - Bit k is high for exactly one cycle, the cycle after a bus write commits to register k. This coincides with the first b_valid cycle.
  - No pulse for SLVERR writes or for hw_we_i writes.
- Undefined: the port does not exist and the logic is absent.

Decomposition:
- Shared package axi_lite_regfile_pkg contains:
  - resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - enum types wr_state_e {W_IDLE, W_RESP} and rd_state_e {R_IDLE, R_RESP};
  - function idx_width(NUM_REGS).
- One sub-module, axi_lite_regfile_decode: combinational addr -> {idx, hit}, instantiated once for AW and once for AR.

Test Plan:
- Write 0xDEADBEEF to 0x0004 with strb 4'hF, AW and W in the same cycle → b_valid one cycle later with resp 0, then reg_q_o word 1 = 0xDEADBEEF. Read 0x0004 → r_data 0xDEADBEEF, resp 0.
- AW to 0x0008 at cycle 0, W 0x12345678 at cycle 5 → aw_ready=0 during cycles 1-5, b_valid at cycle 6. With b_ready held low for 4 cycles, b_valid stays high and aw_ready/w_ready stay 0.
- Register 2 = 0xAABBCCDD, write 0x11223344 with strb 4'b0101 → register 2 = 0xAA22CC44.
- With NUM_REGS=16, read 0x0040 → r_resp 2'b10, r_data 0. Write 0x1FFC → b_resp 2'b10 and no register changes.
- In the same cycle, hw_we_i[3]=1 with data 0xFFFFFFFF and a bus write commits 0x00000000 with strb 4'b0011 → register 3 = 0xFFFF0000.
- Assert rst_ni=0 for 1 cycle while in W_RESP and R_RESP → all registers 0, b_valid=r_valid=0, readies=1 on the next cycle. With AXI_LITE_REGFILE_WR_PULSE_EN defined, wr_pulse_o[1] pulses exactly once in the first scenario.
